// File: rtl/seq_divider_32b.sv
// Multi-cycle restoring divider (signed or unsigned), one quotient bit per clock.
// Optional macro DIV_EARLY_OUT_EN: skip the iteration when |divisor| > |dividend|.
module seq_divider_32b #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  // Handshake: start is sampled only while busy=0; done pulses for one cycle
  // with results that stay stable until the next completed operation.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    L_CNT_W   = CW'(WIDTH);
  localparam logic [CW-1:0]    L_CNT_ONE = CW'(1);
  localparam logic [WIDTH-1:0] L_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH+1:0] L_ONE_X   = {{(WIDTH+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DIV  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;
  logic             r_done;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dvs_abs;
  logic             w_dvs_zero;
  logic             w_early;
  logic             w_accept;
  logic             w_short;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH+1:0] w_trial;
  logic             w_trial_ok;
  logic [WIDTH-1:0] w_quo_neg;
  logic [WIDTH-1:0] w_rem_neg;

  // Negation reuses the adder form a + ~b + 1 with a = 0.
  assign w_dvd_neg  = SIGNED & dividend[WIDTH-1];
  assign w_dvs_neg  = SIGNED & divisor[WIDTH-1];
  assign w_dvd_abs  = w_dvd_neg ? (~dividend + L_ONE) : dividend;
  assign w_dvs_abs  = w_dvs_neg ? (~divisor + L_ONE) : divisor;
  assign w_dvs_zero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_dvs_zero && (w_dvs_abs > w_dvd_abs);
`else
  assign w_early = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_short  = w_dvs_zero || w_early;

  // Shifted remainder can reach 2*|divisor|, so the trial needs two extra bits;
  // a non-negative trial is always below |divisor| and has both top bits clear.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_trial    = {1'b0, w_rem_sh} + {2'b11, ~r_dvs} + L_ONE_X;
  assign w_trial_ok = ~|w_trial[WIDTH+1:WIDTH];

  assign w_quo_neg = ~r_quo + L_ONE;
  assign w_rem_neg = ~r_rem + L_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = w_short ? S_FIX : S_DIV;
      S_DIV:   if (r_cnt == L_CNT_ONE) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem         <= '0;
      r_quo         <= '0;
      r_dvs         <= '0;
      r_cnt         <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dbz         <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_dvs    <= w_dvs_abs;
        r_sign_q <= w_dvd_neg ^ w_dvs_neg;
        r_sign_r <= w_dvd_neg;
        r_dbz    <= w_dvs_zero;
        r_cnt    <= L_CNT_W;
        // Short paths park |dividend| as the remainder so the sign fix
        // restores the original dividend.
        if (w_short) begin
          r_rem <= w_dvd_abs;
          r_quo <= '0;
        end else begin
          r_rem <= '0;
          r_quo <= w_dvd_abs;
        end
      end else if (r_state == S_DIV) begin
        r_rem <= w_trial_ok ? w_trial[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_trial_ok};
        r_cnt <= r_cnt - L_CNT_ONE;
      end else if (r_state == S_FIX) begin
        r_quotient    <= r_dbz ? '1 : (r_sign_q ? w_quo_neg : r_quo);
        r_remainder   <= r_sign_r ? w_rem_neg : r_rem;
        r_div_by_zero <= r_dbz;
        r_done        <= 1'b1;
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_seq_divider_32b.sv
// Table-driven bench for seq_divider_32b: one signed and one unsigned instance,
// plus hand-written reset, divide-by-zero and back-to-back handshake sequences.
module tb_seq_divider_32b;

`ifdef DIV_EARLY_OUT_EN
  localparam int EARLY_LAT = 1;
`else
  localparam int EARLY_LAT = 33;
`endif
  localparam int FULL_LAT = 33;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s, start_u;
  logic [31:0] dividend, divisor;
  logic        busy_s, done_s, dbz_s;
  logic        busy_u, done_u, dbz_u;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [1:0]  st_s, st_u;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_divider_32b #(.WIDTH(32), .SIGNED(1'b1)) u_dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dividend(dividend), .divisor(divisor),
    .busy(busy_s), .done(done_s), .quotient(q_s), .remainder(r_s),
    .div_by_zero(dbz_s), .dbg_state(st_s)
  );

  seq_divider_32b #(.WIDTH(32), .SIGNED(1'b0)) u_dut_u (
    .clk(clk), .rst_n(rst_n), .start(start_u), .dividend(dividend), .divisor(divisor),
    .busy(busy_u), .done(done_u), .quotient(q_u), .remainder(r_u),
    .div_by_zero(dbz_u), .dbg_state(st_u)
  );

  // kind: 0 = full latency, 1 = divide by zero, 2 = early-out candidate
  typedef struct {
    logic        sel_u;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        z;
    int          kind;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic sample(input logic sel_u, output logic [31:0] q, output logic [31:0] r,
                        output logic z, output logic b, output logic d);
    if (sel_u) begin
      q = q_u; r = r_u; z = dbz_u; b = busy_u; d = done_u;
    end else begin
      q = q_s; r = r_s; z = dbz_s; b = busy_s; d = done_s;
    end
  endtask

  // Counts edges after the accept edge until done, bounded by 40.
  task automatic wait_done(input logic sel_u, input string name, output int n, output logic ok);
    logic [31:0] q, r;
    logic z, b, d;
    n = 0;
    d = 1'b0;
    while (!d && n < 40) begin
      @(posedge clk); #1;
      n++;
      sample(sel_u, q, r, z, b, d);
    end
    ok = d;
    if (!d) check({name, " done timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_result(input logic sel_u, input string name, input int n, input int elat,
                              input logic [31:0] eq, input logic [31:0] er, input logic ez);
    logic [31:0] q, r;
    logic z, b, d;
    sample(sel_u, q, r, z, b, d);
    check({name, " latency"}, 32'(n), 32'(elat));
    check({name, " quotient"}, q, eq);
    check({name, " remainder"}, r, er);
    check({name, " div_by_zero"}, {31'd0, z}, {31'd0, ez});
    check({name, " busy at done"}, {31'd0, b}, 32'd0);
  endtask

  task automatic run_op(input logic sel_u, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eq, input logic [31:0] er, input logic ez,
                        input int elat, input string name);
    logic [31:0] q, r;
    logic z, bsy, d, ok;
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    if (sel_u) start_u = 1'b1;
    else       start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    start_u = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    sample(sel_u, q, r, z, bsy, d);
    check({name, " busy after accept"}, {31'd0, bsy}, 32'd1);
    wait_done(sel_u, name, n, ok);
    if (ok) begin
      check_result(sel_u, name, n, elat, eq, er, ez);
      @(posedge clk); #1;
      sample(sel_u, q, r, z, bsy, d);
      check({name, " done pulse width"}, {31'd0, d}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] q, r;
    logic z, b, d, ok;
    int n, elat;

    rst_n = 1'b0;
    start_s = 1'b0;
    start_u = 1'b0;
    dividend = '0;
    divisor = '0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 0};
    vecs[1]  = '{1'b0, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 0};
    vecs[2]  = '{1'b0, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 0};
    vecs[3]  = '{1'b0, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0, 0};
    vecs[4]  = '{1'b0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 1};
    vecs[5]  = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 0};
    vecs[6]  = '{1'b1, 32'hFFFFFFFF,   32'h10,         32'h0FFFFFFF,   32'hF,          1'b0, 0};
    vecs[7]  = '{1'b1, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 2};
    vecs[8]  = '{1'b0, 32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 2};
    vecs[9]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 2};
    vecs[10] = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 0};
    vecs[11] = '{1'b0, 32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0, 0};
    vecs[12] = '{1'b0, 32'hFFFFFFF7,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF7,   1'b1, 1};
    vecs[13] = '{1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 0};

    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sample(s[0], q, r, z, b, d);
      check($sformatf("reset%0d q", s), q, 32'd0);
      check($sformatf("reset%0d r", s), r, 32'd0);
      check($sformatf("reset%0d flags", s), {29'd0, z, b, d}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      elat = (vecs[i].kind == 1) ? 1 : (vecs[i].kind == 2) ? EARLY_LAT : FULL_LAT;
      run_op(vecs[i].sel_u, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].z,
             elat, $sformatf("vec%0d", i));
    end

    // Reset in the middle of an operation discards it and clears the outputs.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start_s  = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset q", q_s, 32'd0);
    check("midreset r", r_s, 32'd0);
    check("midreset flags", {29'd0, dbz_s, busy_s, done_s}, 32'd0);
    check("midreset state", {30'd0, st_s}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, FULL_LAT, "after reset");

    // Start held high: only one op while busy, then re-accepted in the done cycle.
    @(negedge clk);
    dividend = 32'd100;
    divisor  = 32'd7;
    start_s  = 1'b1;
    @(posedge clk); #1;
    dividend = 32'd9;
    divisor  = 32'd3;
    check("held busy", {31'd0, busy_s}, 32'd1);
    wait_done(1'b0, "held", n, ok);
    if (ok) begin
      check_result(1'b0, "held", n, FULL_LAT, 32'd14, 32'd2, 1'b0);
      @(posedge clk); #1;
      start_s = 1'b0;
      check("b2b accept busy", {31'd0, busy_s}, 32'd1);
      check("b2b accept done low", {31'd0, done_s}, 32'd0);
      wait_done(1'b0, "b2b", n, ok);
      if (ok) check_result(1'b0, "b2b", n, FULL_LAT, 32'd3, 32'd0, 1'b0);
    end
    start_s = 1'b0;

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
